instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0013, instruction_out value after reset (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  downstream IF/ID register cannot accept a new instruction this cycle.
REQ-006 redirect_valid  input  1  branch/jump taken; fetch SHALL restart at redirect_pc.
REQ-007 redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 2'b00.
REQ-008 imem_req  output  1  instruction memory read request, one-cycle pulse per request.
REQ-009 imem_addr  output  32  word-aligned read address, valid while imem_req=1.
REQ-010 imem_rvalid  input  1  read data valid; at most one response per request, any latency >=1 cycle.
REQ-011 imem_rdata  input  32  instruction word returned with imem_rvalid.
REQ-012 instruction_out  output  32  registered fetched instruction, drives IF/ID instruction_in.
REQ-013 pc_out  output  32  registered PC of instruction_out.
REQ-014 instr_valid  output  1  registered; high exactly one cycle per delivered instruction.

Function
REQ-015 Internal state: pc register (32), FSM {FETCH, WAIT, HOLD}, discard flag, 32-bit hold buffer.
REQ-016 At most one memory request outstanding; no new imem_req while in WAIT.
REQ-017 FETCH: imem_req=1, imem_addr=pc; next state WAIT.
REQ-018 WAIT, imem_rvalid=1, discard=0, stall=0: instruction_out<=imem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+4, next FETCH.
REQ-019 WAIT, imem_rvalid=1, discard=0, stall=1: hold buffer<=imem_rdata, next HOLD, instr_valid<=0.
REQ-020 WAIT, imem_rvalid=1, discard=1: response dropped, discard<=0, next FETCH, instr_valid<=0.
REQ-021 HOLD, stall=0: instruction_out<=hold buffer, pc_out<=pc, instr_valid<=1, pc<=pc+4, next FETCH.
REQ-022 HOLD, stall=1: remain HOLD, outputs unchanged, instr_valid<=0.
REQ-023 Priority: rst > redirect_valid > imem_rvalid > stall.
REQ-024 redirect_valid in FETCH: request still issued at old pc; pc<={redirect_pc[31:2],2'b00}; discard<=1; next WAIT.
REQ-025 redirect_valid in WAIT without imem_rvalid: pc<=redirect target, discard<=1, stay WAIT.
REQ-026 redirect_valid in WAIT with imem_rvalid same cycle: response dropped, pc<=redirect target, discard<=0, next FETCH.
REQ-027 redirect_valid in HOLD: hold buffer dropped, pc<=redirect target, next FETCH.
REQ-028 Any redirect cycle: instr_valid<=0; instruction_out/pc_out hold previous values.
REQ-029 Cycles not covered above: instruction_out/pc_out hold, instr_valid<=0.
REQ-030 pc increment is modulo 2^32: 32'hFFFF_FFFC+4 -> 32'h0000_0000.
REQ-031 Minimum throughput with 1-cycle memory latency and no stall: one instruction per 2 cycles.
REQ-032 imem_rvalid in FETCH or HOLD (protocol violation) SHALL be ignored.

Reset
REQ-033 While rst=1: pc<=RESET_PC, state<=FETCH, discard<=0, instruction_out<=NOP_INSTR, pc_out<=0, instr_valid<=0, imem_req=0.
REQ-034 First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
REQ-035 rst asserted mid-WAIT: outstanding response arriving after reset release while in FETCH is ignored per REQ-032; response arriving in the following WAIT is accepted as the reset fetch (memory SHALL be quiesced by reset).

Verification
REQ-036 Reset, 1-cycle memory, mem[0]=A, mem[4]=B, no stall -> instr_valid pulses with (A,pc 0) then (B,pc 4), imem_addr sequence 0,4,8.
REQ-037 Response for pc 8 arrives with stall=1 for 3 cycles -> state HOLD, instr_valid=0 for 3 cycles, then one pulse with mem[8], pc_out=8, next imem_addr=12.
REQ-038 redirect_valid with redirect_pc=32'h100 while WAIT for pc 0x10, 4-cycle latency -> stale data never delivered, next imem_addr=0x100, next delivered pc_out=0x100.
REQ-039 redirect_valid coincident with imem_rvalid -> no instr_valid that cycle, imem_req next cycle at redirect target.
REQ-040 redirect_pc=32'hFFFF_FFFE -> imem_addr=32'hFFFF_FFFC; after delivery next imem_addr=32'h0000_0000.
REQ-041 rst pulsed while HOLD -> instr_valid=0, instruction_out=32'h0000_0013, next imem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one word read at a time, delivers each
// returned instruction with its PC, and supports stall and redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        discard_q;
  logic [31:0] hold_buf_q;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic        valid_q;

  // Redirect target with the byte-offset bits forced to zero.
  logic [31:0] redirect_tgt;
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // Request is a pure function of state; suppressed while reset is held.
  assign imem_req        = (state_q == FETCH) && !rst;
  assign imem_addr       = pc_q;
  assign instruction_out = instr_q;
  assign pc_out          = pc_out_q;
  assign instr_valid     = valid_q;

  // Fetch FSM with registered delivery outputs; redirect outranks a
  // returning response, which outranks stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      state_q    <= FETCH;
      discard_q  <= 1'b0;
      hold_buf_q <= 32'h0;
      instr_q    <= NOP_INSTR;
      pc_out_q   <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        FETCH: begin
          // The request at the old pc goes out regardless; a redirect
          // here marks its response as stale.
          state_q <= WAIT;
          if (redirect_valid) begin
            pc_q      <= redirect_tgt;
            discard_q <= 1'b1;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pc_q <= redirect_tgt;
            if (imem_rvalid) begin
              // Stale response consumed this cycle; nothing left in flight.
              discard_q <= 1'b0;
              state_q   <= FETCH;
            end else begin
              // Response still in flight; drop it when it arrives.
              discard_q <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (discard_q) begin
              discard_q <= 1'b0;
              state_q   <= FETCH;
            end else if (!stall) begin
              instr_q  <= imem_rdata;
              pc_out_q <= pc_q;
              valid_q  <= 1'b1;
              pc_q     <= pc_q + 32'd4;
              state_q  <= FETCH;
            end else begin
              hold_buf_q <= imem_rdata;
              state_q    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_q    <= redirect_tgt;
            state_q <= FETCH;
          end else if (!stall) begin
            instr_q  <= hold_buf_q;
            pc_out_q <= pc_q;
            valid_q  <= 1'b1;
            pc_q     <= pc_q + 32'd4;
            state_q  <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a variable-latency memory model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        instr_valid;

    int n_cmp;
    int n_err;

    // memory model state
    int          lat;
    bit          pend;
    logic [31:0] pend_addr;
    int          cnt;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instruction_out(instruction_out),
        .pc_out         (pc_out),
        .instr_valid    (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    `define CHK(tag, obs, exp) \
        begin \
            n_cmp++; \
            assert ((obs) === (exp)) else begin \
                n_err++; \
                $error("FAIL %s: observed %h expected %h", tag, (obs), (exp)); \
            end \
        end

    always @(negedge clk) begin
        if (imem_req === 1'b1) begin
            n_cmp++;
            if (imem_addr[1:0] !== 2'b00) begin
                n_err++;
                $error("FAIL mon_align: imem_addr %h not word aligned", imem_addr);
            end
        end
        if (rst === 1'b1) begin
            n_cmp++;
            if (imem_req !== 1'b0) begin
                n_err++;
                $error("FAIL mon_rst_req: imem_req %b during reset", imem_req);
            end
        end
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // One clock: memory latches a request just before the edge, then
    // presents any due response shortly after the edge.
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            pend = 1'b0;
        end else if (imem_req) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            cnt       = lat;
        end
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                pend        = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        lat = 1;
        pend = 1'b0;
        cnt = 0;
        pend_addr = 32'h0;
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;

        // Reset state
        tick(); tick(); tick();
        `CHK("rst_valid", instr_valid, 1'b0)
        `CHK("rst_instr", instruction_out, 32'h0000_0013)
        `CHK("rst_pc_out", pc_out, 32'h0)
        `CHK("rst_req", imem_req, 1'b0)
        rst = 1'b0;
        #1;
        `CHK("first_req", imem_req, 1'b1)
        `CHK("first_addr", imem_addr, 32'h0)

        // Back-to-back fetch, 1-cycle memory, no stall
        tick();
        `CHK("wait0_req", imem_req, 1'b0)
        `CHK("wait0_valid", instr_valid, 1'b0)
        tick();
        `CHK("A_valid", instr_valid, 1'b1)
        `CHK("A_instr", instruction_out, 32'hC0DE_0000)
        `CHK("A_pc", pc_out, 32'h0)
        `CHK("A_next_addr", imem_addr, 32'h4)
        tick();
        `CHK("A_pulse_end", instr_valid, 1'b0)
        tick();
        `CHK("B_valid", instr_valid, 1'b1)
        `CHK("B_instr", instruction_out, 32'hC0DE_0004)
        `CHK("B_pc", pc_out, 32'h4)
        `CHK("B_next_addr", imem_addr, 32'h8)

        // Response for pc 8 arrives under a 3-cycle stall
        stall = 1'b1;
        tick();
        tick();
        `CHK("hold1_valid", instr_valid, 1'b0)
        `CHK("hold1_req", imem_req, 1'b0)
        tick();
        `CHK("hold2_valid", instr_valid, 1'b0)
        tick();
        `CHK("hold3_valid", instr_valid, 1'b0)
        `CHK("hold3_instr", instruction_out, 32'hC0DE_0004)
        stall = 1'b0;
        tick();
        `CHK("C_valid", instr_valid, 1'b1)
        `CHK("C_instr", instruction_out, 32'hC0DE_0008)
        `CHK("C_pc", pc_out, 32'h8)
        `CHK("C_next_addr", imem_addr, 32'hC)

        // Deliver pc 12, then redirect while waiting on pc 0x10 (4-cycle memory)
        tick();
        tick();
        `CHK("D_pc", pc_out, 32'hC)
        lat = 4;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        `CHK("redir_wait_valid", instr_valid, 1'b0)
        `CHK("redir_wait_req", imem_req, 1'b0)
        tick();
        tick();
        `CHK("stale_arrives", imem_rvalid, 1'b1)
        tick();
        `CHK("stale_dropped_valid", instr_valid, 1'b0)
        `CHK("stale_dropped_instr", instruction_out, 32'hC0DE_000C)
        `CHK("redir_addr", imem_addr, 32'h100)
        `CHK("redir_req", imem_req, 1'b1)
        lat = 1;
        tick();
        tick();
        `CHK("E_valid", instr_valid, 1'b1)
        `CHK("E_instr", instruction_out, 32'hC0DE_0100)
        `CHK("E_pc", pc_out, 32'h100)

        // Redirect coincident with the response
        tick();
        `CHK("coinc_rvalid", imem_rvalid, 1'b1)
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        `CHK("coinc_valid", instr_valid, 1'b0)
        `CHK("coinc_req", imem_req, 1'b1)
        `CHK("coinc_addr", imem_addr, 32'h200)
        `CHK("coinc_instr", instruction_out, 32'hC0DE_0100)

        // Redirect during FETCH to an unaligned top-of-memory target
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        `CHK("fetch_redir_valid", instr_valid, 1'b0)
        tick();
        `CHK("wrap_req", imem_req, 1'b1)
        `CHK("wrap_addr", imem_addr, 32'hFFFF_FFFC)
        `CHK("wrap_no_stale", instr_valid, 1'b0)
        tick();
        tick();
        `CHK("F_valid", instr_valid, 1'b1)
        `CHK("F_instr", instruction_out, 32'hC0DE_FFFC)
        `CHK("F_pc", pc_out, 32'hFFFF_FFFC)
        `CHK("F_wrap_addr", imem_addr, 32'h0)

        // Reset pulsed while in HOLD
        stall = 1'b1;
        tick();
        tick();
        `CHK("G_hold_valid", instr_valid, 1'b0)
        rst = 1'b1;
        tick();
        `CHK("G_rst_valid", instr_valid, 1'b0)
        `CHK("G_rst_instr", instruction_out, 32'h0000_0013)
        `CHK("G_rst_pc_out", pc_out, 32'h0)
        rst = 1'b0;
        stall = 1'b0;
        #1;
        `CHK("G_req", imem_req, 1'b1)
        `CHK("G_addr", imem_addr, 32'h0)
        tick();
        tick();
        `CHK("G_valid", instr_valid, 1'b1)
        `CHK("G_instr", instruction_out, 32'hC0DE_0000)
        `CHK("G_pc", pc_out, 32'h0)

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
